imem_boot_loader: RTL



---
 rtl/imem_boot_loader_pkg.sv | 16 +
 rtl/imem_word_packer.sv | 45 ++++
 rtl/imem_boot_loader.sv | 122 ++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared types for the instruction memory boot loader.
// State encoding and checksum seed.
package imem_boot_loader_pkg;

   typedef enum logic [2:0] {
      LEN_LO,
      LEN_HI,
      DATA,
      CHK,
      RUN,
      ERR
   } state_e;

   localparam logic [7:0] CHK_SEED = 8'h00;

endpackage

// File: rtl/imem_word_packer.sv
// Packs little-endian bytes into 32-bit words.
// Emits one registered write pulse per completed word.
module imem_word_packer #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   input  logic [ADDR_W-1:0] word_addr,
   output logic              word_done,
   output logic              we,
   output logic [ADDR_W-1:0] addr,
   output logic [31:0]       wdata
);

   logic [1:0]  cnt_q;
   logic [23:0] acc_q;

   assign word_done = byte_valid && (cnt_q == 2'd3);

   always_ff @(posedge clk) begin
      if (clear) begin
         cnt_q <= '0;
         acc_q <= '0;
         we    <= 1'b0;
         addr  <= '0;
         wdata <= '0;
      end else begin
         we <= 1'b0;
         if (byte_valid) begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               we    <= 1'b1;
               addr  <= word_addr;
               wdata <= {byte_data, acc_q};
            end else begin
               // Oldest byte ends up in bits 7:0 after three shifts
               acc_q <= {byte_data, acc_q[23:8]};
            end
         end
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checked program image into imem.
// Holds the core in reset until the image is verified.
module imem_boot_loader
   import imem_boot_loader_pkg::*;
#(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_reset,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   localparam logic [16:0]   DEPTH_L = 17'(2 ** ADDR_W);
   localparam logic [ADDR_W:0] ONE_W = 1;

   state_e          state, state_nxt;
   logic [7:0]      len_lo_q;
   logic [ADDR_W:0] len_q;
   logic [7:0]      csum_q;
   logic [ADDR_W:0] words_q;
   logic [15:0]     n16;
   logic            acc;
   logic            data_acc;
   logic            word_done;
   logic            last_word;

   assign acc       = in_valid && in_ready;
   assign data_acc  = acc && (state == DATA);
   assign n16       = {in_data, len_lo_q};
   assign last_word = (words_q + ONE_W) == len_q;

   assign words_loaded = words_q;

   imem_word_packer #(
      .ADDR_W(ADDR_W)
   ) u_packer (
      .clk       (clk),
      .clear     (reset),
      .byte_valid(data_acc),
      .byte_data (in_data),
      .word_addr (words_q[ADDR_W-1:0]),
      .word_done (word_done),
      .we        (imem_we),
      .addr      (imem_addr),
      .wdata     (imem_wdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= LEN_LO;
         len_lo_q <= '0;
         len_q    <= '0;
         csum_q   <= CHK_SEED;
         words_q  <= '0;
      end else begin
         state <= state_nxt;
         if (acc && state == LEN_LO)
            len_lo_q <= in_data;
         if (acc && state == LEN_HI)
            len_q <= n16[ADDR_W:0];
         if (data_acc)
            csum_q <= csum_q ^ in_data;
         // Counts in step with the packer's write pulse
         if (word_done)
            words_q <= words_q + ONE_W;
      end
   end

   always_comb begin
      state_nxt  = state;
      in_ready   = 1'b0;
      core_reset = 1'b1;
      done       = 1'b0;
      error      = 1'b0;
      unique case (state)
         LEN_LO: begin
            in_ready = 1'b1;
            if (acc)
               state_nxt = LEN_HI;
         end
         LEN_HI: begin
            in_ready = 1'b1;
            if (acc) begin
               if (n16 == 16'd0)
                  state_nxt = CHK;
               else if ({1'b0, n16} > DEPTH_L)
                  state_nxt = ERR;
               else
                  state_nxt = DATA;
            end
         end
         DATA: begin
            in_ready = 1'b1;
            if (word_done && last_word)
               state_nxt = CHK;
         end
         CHK: begin
            in_ready = 1'b1;
            if (acc)
               state_nxt = (in_data == csum_q) ? RUN : ERR;
         end
         RUN: begin
            core_reset = 1'b0;
            done       = 1'b1;
         end
         ERR: begin
            error = 1'b1;
         end
         default: state_nxt = ERR;
      endcase
   end

endmodule
